// File: rtl/gelu_cube_root_calculator.sv
// ----------------------------------------------------------------------------
// gelu_cube_root_calculator
//
// Iterative signed Q8.16 cube root. Resolves one result bit per clock with
// a restoring trial-and-compare: each cycle it sets the next lower root bit,
// cubes the trial value and keeps the bit if the cube still fits under the
// radicand. The result is truncated toward zero, so exact cubes return exact
// roots. The unit accepts one operand per ROOT_BITS+1 cycles.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset; aborts any calculation
//   x_in        signed Q8.16 operand, sampled on accept
//   valid_in    operand valid
//   ready_out   high in IDLE; accept = valid_in && ready_out at a clock edge
//   x_cbrt_out  signed Q8.16 cube root, held until the next result
//   valid_out   one-cycle pulse marking a new x_cbrt_out
// ----------------------------------------------------------------------------
module gelu_cube_root_calculator #(
    parameter int DATA_WIDTH = 24,
    parameter int FRAC_BITS  = 16,
    parameter int ROOT_BITS  = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] x_cbrt_out,
    output logic                  valid_out
);

    // Radicand is |x| scaled by 2^(2*FRAC_BITS) so the root comes out in
    // the same Q format as the operand.
    localparam int RAD_W  = DATA_WIDTH + 2 * FRAC_BITS;
    // Cube of a ROOT_BITS-wide trial, plus one spare bit so the compare is
    // never truncated.
    localparam int CMP_W  = 3 * ROOT_BITS + 1;
    localparam int IDX_W  = $clog2(ROOT_BITS);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [RAD_W-1:0]        rad_q, rad_d;
    logic [ROOT_BITS-1:0]    y_q, y_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]   x_cbrt_q, x_cbrt_d;
    logic                    valid_out_q, valid_out_d;

    logic [DATA_WIDTH-1:0]   mag;
    logic [ROOT_BITS-1:0]    trial;
    logic [CMP_W-1:0]        trial_ext;
    logic [CMP_W-1:0]        trial_cube;
    logic                    trial_fits;
    logic [DATA_WIDTH-1:0]   root_ext;

    always_comb begin
        // Two's-complement magnitude; the most negative operand maps to
        // 2^(DATA_WIDTH-1), which still fits as an unsigned value.
        mag        = x_in[DATA_WIDTH-1] ? (~x_in + 1'b1) : x_in;

        trial      = y_q | (ROOT_BITS'(1) << bit_idx_q);
        trial_ext  = CMP_W'(trial);
        trial_cube = trial_ext * trial_ext * trial_ext;
        trial_fits = (trial_cube <= CMP_W'(rad_q));

        state_d     = state_q;
        sign_d      = sign_q;
        rad_d       = rad_q;
        y_d         = y_q;
        bit_idx_d   = bit_idx_q;
        x_cbrt_d    = x_cbrt_q;
        valid_out_d = 1'b0;
        root_ext    = '0;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    sign_d    = x_in[DATA_WIDTH-1];
                    rad_d     = RAD_W'(mag) << (2 * FRAC_BITS);
                    y_d       = '0;
                    bit_idx_d = IDX_W'(ROOT_BITS - 1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (trial_fits) begin
                    y_d = trial;
                end
                if (bit_idx_q == '0) begin
                    // Negating zero yields zero, so no negative-zero case.
                    root_ext    = DATA_WIDTH'(y_d);
                    x_cbrt_d    = sign_q ? (~root_ext + 1'b1) : root_ext;
                    valid_out_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            rad_q       <= '0;
            y_q         <= '0;
            bit_idx_q   <= '0;
            x_cbrt_q    <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            rad_q       <= rad_d;
            y_q         <= y_d;
            bit_idx_q   <= bit_idx_d;
            x_cbrt_q    <= x_cbrt_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign ready_out  = (state_q == IDLE);
    assign x_cbrt_out = x_cbrt_q;
    assign valid_out  = valid_out_q;

endmodule
